dmem_responder: RTL and testbench

Data-memory responder for the five-stage RISC-V core: the slave end of the pipeline's load/store interface. It accepts one request at a time from the memory stage over a valid/ready channel and decodes RISC-V `funct3` access sizes. It services the request against byte-addressable little-endian storage after a fixed, parameterised latency, then returns read data or an error on a valid/ready response channel. It replaces the single-cycle data port so that the core can be tested against realistic memory latency.

---
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder.sv | 188 ++++++++++++++++++
 tb/tb_dmem_responder.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store channel between the memory stage (master) and a data-memory responder (slave).
interface dmem_responder_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AWIDTH-1:0] req_addr;
    logic [2:0]        req_funct3;
    logic [DWIDTH-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency little-endian data-memory responder for the five-stage core's load/store port.
//   state | meaning
//   IDLE  | waiting for a request (req_ready high once out of reset)
//   BUSY  | counting down the access latency
//   RESP  | response held until rsp_ready
module dmem_responder #(
    parameter int unsigned       AWIDTH    = 32,
    parameter int unsigned       DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 'h01000000,
    parameter int unsigned       MEM_DEPTH = 1048576,
    parameter int unsigned       LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    dmem_responder_if.slave   bus
);

    localparam int unsigned WORDS = MEM_DEPTH / 4;
    localparam int unsigned IDXW  = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned OFFW  = IDXW + 2;
    localparam int unsigned CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [AWIDTH:0] ADDR_LO  = {1'b0, BASE_ADDR};
    localparam logic [AWIDTH:0] ADDR_HI  = ADDR_LO + (AWIDTH + 1)'(MEM_DEPTH);
    localparam logic [CW-1:0]   CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [OFFW-1:0]   off_q, off_d;
    logic              err_q, err_d;

    logic [DWIDTH-1:0] mem_q [WORDS];

    logic              in_range;
    logic              misaligned;
    logic              illegal;
    logic              req_err;
    logic              accept;
    logic              commit;
    logic [OFFW-1:0]   req_off;
    logic [3:0]        wr_be;
    logic [DWIDTH-1:0] wr_lane;
    logic [DWIDTH-1:0] rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [DWIDTH-1:0] load_val;

    // Request decode: only the low offset bits index storage; the range check covers the rest.
    always_comb begin
        req_off    = bus.req_addr[OFFW-1:0] - BASE_ADDR[OFFW-1:0];
        in_range   = ({1'b0, bus.req_addr} >= ADDR_LO) && ({1'b0, bus.req_addr} < ADDR_HI);
        misaligned = ((bus.req_funct3[1:0] == 2'd1) && bus.req_addr[0]) ||
                     ((bus.req_funct3[1:0] == 2'd2) && (bus.req_addr[1:0] != 2'd0));
        illegal    = bus.req_we ? (bus.req_funct3 > 3'd2)
                                : ((bus.req_funct3 == 3'd3) || (bus.req_funct3[2:1] == 2'b11));
        req_err    = !in_range || misaligned || illegal;
        accept     = (state_q == ST_IDLE) && req_ready_q && bus.req_valid;
        commit     = accept && bus.req_we && !req_err;
    end

    always_comb begin
        wr_be   = 4'b1111;
        wr_lane = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'd0: begin
                wr_be   = 4'b0001 << req_off[1:0];
                wr_lane = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                wr_be   = 4'b0011 << req_off[1:0];
                wr_lane = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_lane = bus.req_wdata;
            end
        endcase
    end

    // Storage is deliberately outside reset so committed stores survive an aborted transaction.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[req_off[OFFW-1:2]][8*b +: 8] <= wr_lane[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem_q[off_q[OFFW-1:2]];
        case (off_q[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = off_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (f3_q)
            3'd0:    load_val = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_val = {{16{rd_half[15]}}, rd_half};
            3'd4:    load_val = {24'd0, rd_byte};
            3'd5:    load_val = {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        f3_d        = f3_q;
        off_d       = off_q;
        err_d       = err_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_INIT;
                    we_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    off_d   = req_off;
                    err_d   = req_err;
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d     = ST_RESP;
                    rsp_err_d   = err_q;
                    rsp_rdata_d = (err_q || we_q) ? '0 : load_val;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            we_q        <= we_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, reset/backpressure sequences and random traffic vs a byte-array model.
module tb_dmem_responder;

    localparam logic [31:0] BASE   = 32'h01000000;
    localparam longint      DEPTH0 = 1048576;
    localparam int          L0     = 2;
    localparam int          L1     = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if #(.AWIDTH(32), .DWIDTH(32)) bus0 ();
    dmem_responder_if #(.AWIDTH(32), .DWIDTH(32)) bus1 ();

    dmem_responder #(.MEM_DEPTH(1048576), .LATENCY(L0)) u_dut0 (.clk(clk), .rst(rst_n), .bus(bus0));
    dmem_responder #(.MEM_DEPTH(256),     .LATENCY(L1)) u_dut1 (.clk(clk), .rst(rst_n), .bus(bus1));

    bit          sel = 1'b0;
    logic        v_valid = 1'b0, v_we = 1'b0, v_rsp_ready = 1'b0;
    logic [31:0] v_addr = '0, v_wdata = '0;
    logic [2:0]  v_f3 = '0;

    assign bus0.req_valid  = v_valid && !sel;
    assign bus1.req_valid  = v_valid && sel;
    assign bus0.req_we     = v_we;
    assign bus1.req_we     = v_we;
    assign bus0.req_addr   = v_addr;
    assign bus1.req_addr   = v_addr;
    assign bus0.req_funct3 = v_f3;
    assign bus1.req_funct3 = v_f3;
    assign bus0.req_wdata  = v_wdata;
    assign bus1.req_wdata  = v_wdata;
    assign bus0.rsp_ready  = v_rsp_ready;
    assign bus1.rsp_ready  = v_rsp_ready;

    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;
    assign m_req_ready = sel ? bus1.req_ready : bus0.req_ready;
    assign m_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
    assign m_rsp_rdata = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
    assign m_rsp_err   = sel ? bus1.rsp_err   : bus0.rsp_err;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] ref_mem [longint];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    // Architectural model of the LATENCY=2 instance: byte-addressed memory, RISC-V size/extension rules.
    task automatic model(input bit we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wd, output logic [31:0] rd, output bit err);
        longint a;
        longint v;
        int     size;
        bit     illegal;
        a       = longint'(addr);
        size    = 1 << int'(f3[1:0]);
        illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        err     = illegal || (a < longint'(BASE)) || (a >= longint'(BASE) + DEPTH0) ||
                  ((a % size) != 0);
        rd      = '0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < size; i++) ref_mem[a + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < size; i++) v = v | (longint'(ref_mem[a + i]) << (8 * i));
                if (f3 < 3'd4 && size < 4 && v >= (longint'(1) << (8 * size - 1)))
                    v = v - (longint'(1) << (8 * size));
                rd = v[31:0];
            end
        end
    endtask

    task automatic do_req(input int inst, input bit we, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] wd, input int hold, input logic [31:0] exp_rd,
                          input bit exp_err, input string tag);
        int n;
        int lat;
        @(negedge clk);
        sel         = (inst == 1);
        v_we        = we;
        v_addr      = addr;
        v_f3        = f3;
        v_wdata     = wd;
        v_rsp_ready = (hold == 0);
        v_valid     = 1'b1;
        n = 0;
        while (m_req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            timeout_fail({tag, " req_ready"});
            v_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        v_valid = 1'b0;
        lat = 0;
        while (m_rsp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 50) begin
            timeout_fail({tag, " rsp_valid"});
            return;
        end
        chk({tag, " latency"}, 32'(lat), 32'((inst == 1) ? L1 : L0));
        chk({tag, " rdata"}, m_rsp_rdata, exp_rd);
        chk({tag, " err"}, 32'(m_rsp_err), 32'(exp_err));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk({tag, " stall rsp_valid"}, 32'(m_rsp_valid), 32'd1);
            chk({tag, " stall rdata"}, m_rsp_rdata, exp_rd);
            chk({tag, " stall req_ready"}, 32'(m_req_ready), 32'd0);
        end
        v_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " done rsp_valid"}, 32'(m_rsp_valid), 32'd0);
        chk({tag, " done req_ready"}, 32'(m_req_ready), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            n_chk++;
            if ((bus0.req_ready && bus0.rsp_valid) || (bus1.req_ready && bus1.rsp_valid)) begin
                n_fail++;
                $display("FAIL ready_valid_overlap: req_ready and rsp_valid both 1 (t=%0t)", $time);
            end
        end
    end

    typedef struct {
        int          inst;
        bit          we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        int          hold;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int inst, input bit we, input logic [31:0] addr,
                                input logic [2:0] f3, input logic [31:0] wd, input int hold,
                                input logic [31:0] exp_rd, input bit exp_err);
        vec_t v;
        v.inst = inst; v.we = we; v.addr = addr; v.f3 = f3; v.wd = wd;
        v.hold = hold; v.exp_rd = exp_rd; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m_rd;
        bit          m_err;
        logic [31:0] r_addr;
        logic [2:0]  r_f3;
        logic [31:0] r_wd;
        bit          r_we;
        int          r;

        //        inst we addr          f3  wdata          hold exp_rd         err
        add(0, 1, 32'h01000010, 3'd2, 32'hDEADBEEF, 0, 32'h00000000, 0);
        add(0, 0, 32'h01000010, 3'd2, 32'h0,        0, 32'hDEADBEEF, 0);
        add(0, 1, 32'h01000020, 3'd2, 32'h80FF7F01, 0, 32'h00000000, 0);
        add(0, 0, 32'h01000023, 3'd0, 32'h0,        0, 32'hFFFFFF80, 0);
        add(0, 0, 32'h01000023, 3'd4, 32'h0,        0, 32'h00000080, 0);
        add(0, 0, 32'h01000022, 3'd1, 32'h0,        0, 32'hFFFF80FF, 0);
        add(0, 0, 32'h01000020, 3'd5, 32'h0,        0, 32'h00007F01, 0);
        add(0, 1, 32'h01000021, 3'd0, 32'h123456AA, 0, 32'h00000000, 0);
        add(0, 0, 32'h01000020, 3'd2, 32'h0,        0, 32'h80FFAA01, 0);
        add(0, 0, 32'h01000002, 3'd2, 32'h0,        0, 32'h00000000, 1);
        add(0, 1, 32'h01000021, 3'd1, 32'h0000FFFF, 0, 32'h00000000, 1);
        add(0, 0, 32'h00FFFFFC, 3'd2, 32'h0,        0, 32'h00000000, 1);
        add(0, 0, 32'h01000020, 3'd3, 32'h0,        0, 32'h00000000, 1);
        add(0, 1, 32'h01000020, 3'd3, 32'hFFFFFFFF, 0, 32'h00000000, 1);
        add(0, 0, 32'h01000020, 3'd2, 32'h0,        0, 32'h80FFAA01, 0);
        add(0, 1, 32'h010FFFFC, 3'd2, 32'h12345678, 0, 32'h00000000, 0);
        add(0, 0, 32'h010FFFFC, 3'd2, 32'h0,        5, 32'h12345678, 0);
        add(0, 0, 32'h010FFFFE, 3'd1, 32'h0,        0, 32'h00001234, 0);
        add(0, 0, 32'h01100000, 3'd2, 32'h0,        0, 32'h00000000, 1);
        add(0, 1, 32'h01100000, 3'd0, 32'h000000FF, 0, 32'h00000000, 1);
        add(1, 1, 32'h01000010, 3'd2, 32'hCAFEF00D, 0, 32'h00000000, 0);
        add(1, 0, 32'h01000010, 3'd2, 32'h0,        0, 32'hCAFEF00D, 0);
        add(1, 1, 32'h010000FC, 3'd2, 32'h0BADC0DE, 0, 32'h00000000, 0);
        add(1, 0, 32'h010000FC, 3'd2, 32'h0,        2, 32'h0BADC0DE, 0);
        add(1, 0, 32'h010000FF, 3'd0, 32'h0,        0, 32'h0000000B, 0);
        add(1, 0, 32'h01000100, 3'd2, 32'h0,        0, 32'h00000000, 1);
        add(1, 0, 32'h00FFFFFF, 3'd4, 32'h0,        0, 32'h00000000, 1);

        // Reset held through two edges, then released.
        #1;
        chk("reset req_ready0", 32'(bus0.req_ready), 32'd0);
        chk("reset rsp_valid0", 32'(bus0.rsp_valid), 32'd0);
        chk("reset rdata0", bus0.rsp_rdata, 32'd0);
        chk("reset err0", 32'(bus0.rsp_err), 32'd0);
        chk("reset req_ready1", 32'(bus1.req_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release req_ready before edge", 32'(bus0.req_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("release req_ready after edge", 32'(bus0.req_ready), 32'd1);
        chk("release req_ready1 after edge", 32'(bus1.req_ready), 32'd1);

        // Reset while idle, mid-cycle.
        #2;
        rst_n = 1'b0;
        #1;
        chk("idle reset req_ready", 32'(bus0.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle reset req_ready returns", 32'(bus0.req_ready), 32'd1);

        foreach (vecs[i]) begin
            if (vecs[i].inst == 0)
                model(vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wd, m_rd, m_err);
            do_req(vecs[i].inst, vecs[i].we, vecs[i].addr, vecs[i].f3, vecs[i].wd, vecs[i].hold,
                   vecs[i].exp_rd, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Reset in BUSY: store already committed at accept must survive.
        @(negedge clk);
        sel = 1'b0; v_we = 1'b1; v_addr = 32'h01000030; v_f3 = 3'd2; v_wdata = 32'h11223344;
        v_rsp_ready = 1'b1; v_valid = 1'b1;
        @(posedge clk);
        #1;
        v_valid = 1'b0;
        model(1'b1, 32'h01000030, 3'd2, 32'h11223344, m_rd, m_err);
        chk("busy rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("busy reset rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("busy reset req_ready", 32'(bus0.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("busy reset req_ready returns", 32'(bus0.req_ready), 32'd1);
        do_req(0, 1'b0, 32'h01000030, 3'd2, 32'h0, 0, 32'h11223344, 1'b0, "after busy reset");

        // Reset in RESP: response aborted, outputs cleared asynchronously.
        @(negedge clk);
        sel = 1'b0; v_we = 1'b0; v_addr = 32'h01000010; v_f3 = 3'd2;
        v_rsp_ready = 1'b0; v_valid = 1'b1;
        @(posedge clk);
        #1;
        v_valid = 1'b0;
        r = 0;
        while (bus0.rsp_valid !== 1'b1 && r < 50) begin
            @(posedge clk);
            #1;
            r++;
        end
        if (r >= 50) timeout_fail("resp reset wait");
        chk("resp before reset rdata", bus0.rsp_rdata, 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("resp reset rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("resp reset rdata", bus0.rsp_rdata, 32'd0);
        chk("resp reset err", 32'(bus0.rsp_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("resp reset req_ready returns", 32'(bus0.req_ready), 32'd1);

        // Fill a 64-byte window so random loads never touch unwritten storage.
        for (int w = 0; w < 16; w++) begin
            r_wd = $urandom;
            model(1'b1, BASE + 32'h100 + 32'(4 * w), 3'd2, r_wd, m_rd, m_err);
            do_req(0, 1'b1, BASE + 32'h100 + 32'(4 * w), 3'd2, r_wd, 0, m_rd, m_err, "fill");
        end

        for (int t = 0; t < 300; t++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8)       r_addr = BASE + 32'h100 + $urandom_range(0, 63);
            else if (r == 8) r_addr = BASE - 32'd1 - $urandom_range(0, 7);
            else             r_addr = BASE + 32'(DEPTH0) - 32'd4 + $urandom_range(0, 7);
            r_we = ($urandom_range(0, 2) == 0);
            r_f3 = 3'($urandom_range(0, 7));
            r_wd = $urandom;
            model(r_we, r_addr, r_f3, r_wd, m_rd, m_err);
            do_req(0, r_we, r_addr, r_f3, r_wd, int'($urandom_range(0, 3)), m_rd, m_err,
                   $sformatf("rand%0d", t));
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
